// File: rtl/fifo_pkg.sv
// Shared FIFO package: default sizes and Gray/binary pointer conversion helpers.
package fifo_pkg;

  localparam int unsigned ADDR_SIZE_DEF  = 4;
  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned PTR_MAX_W      = 17;

  typedef logic [PTR_MAX_W-1:0] ptr_max_t;

  // Narrower pointers are zero-extended into ptr_max_t and truncated back by the caller.
  function automatic ptr_max_t bin2gray(input ptr_max_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_max_t gray2bin(input ptr_max_t g);
    ptr_max_t b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin winner select: first active req after last_idx, wrapping.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_idx,
  output logic               valid,
  output logic [IW-1:0]      winner
);

  logic [IW-1:0] idx;

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = IW'((32'(last_idx) + i) % NUM_REQ);
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Async FIFO write side: round-robin write-port arbiter, write pointer and full flag.
// Optional almost_full output enabled by defining FIFO_ARB_ALMOST_FULL_EN.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int unsigned addr_size  = ADDR_SIZE_DEF,
  parameter int unsigned data_width = DATA_WIDTH_DEF,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned AF_MARGIN  = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*data_width-1:0] req_data,
  input  logic [addr_size:0]            rd_ptr_gray_sync,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          wr_en,
  output logic [addr_size-1:0]          wr_addr,
  output logic [data_width-1:0]         wr_data,
  output logic [addr_size:0]            wr_ptr_gray,
`ifdef FIFO_ARB_ALMOST_FULL_EN
  output logic                          almost_full,
`endif
  output logic                          full
);

  localparam int unsigned PW = addr_size + 1;
  localparam int unsigned IW = $clog2(NUM_REQ);

  logic [PW-1:0] wr_ptr_bin;
  logic [PW-1:0] bin_nxt;
  logic [PW-1:0] gray_nxt;
  logic [PW-1:0] full_gray;
  logic [IW-1:0] last_idx;
  logic [IW-1:0] winner;
  logic          valid;
  logic          fire;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req      (req),
    .last_idx (last_idx),
    .valid    (valid),
    .winner   (winner)
  );

  assign fire     = valid & ~full;
  assign bin_nxt  = wr_ptr_bin + PW'(fire);
  assign gray_nxt = PW'(bin2gray(PTR_MAX_W'(bin_nxt)));
  // Full when write pointer is exactly one lap ahead: top two Gray bits inverted.
  assign full_gray = {~rd_ptr_gray_sync[PW-1:PW-2], rd_ptr_gray_sync[PW-3:0]};

`ifdef FIFO_ARB_ALMOST_FULL_EN
  logic [PW-1:0] rd_bin;
  logic [PW-1:0] occ;

  assign rd_bin = PW'(gray2bin(PTR_MAX_W'(rd_ptr_gray_sync)));
  assign occ    = bin_nxt - rd_bin;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      almost_full <= 1'b0;
    end else begin
      almost_full <= (occ >= PW'((1 << addr_size) - AF_MARGIN));
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_bin  <= '0;
      wr_ptr_gray <= '0;
      last_idx    <= IW'(NUM_REQ - 1);
      gnt         <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      full        <= 1'b0;
    end else begin
      wr_ptr_bin  <= bin_nxt;
      wr_ptr_gray <= gray_nxt;
      full        <= (gray_nxt == full_gray);
      wr_en       <= fire;
      gnt         <= '0;
      if (fire) begin
        gnt      <= NUM_REQ'(1) << winner;
        last_idx <= winner;
        wr_addr  <= wr_ptr_bin[addr_size-1:0];
        wr_data  <= req_data[winner*data_width +: data_width];
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter (depth 4): directed vector table, async reset sequence, random vs occupancy model.
module tb_fifo_wr_arbiter;

  localparam int unsigned AS = 2;
  localparam int unsigned DW = 8;
  localparam int unsigned NR = 4;
  localparam int unsigned DEPTH = 1 << AS;
  localparam int unsigned AFM = 1;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [NR-1:0]   req = '0;
  logic [NR*DW-1:0] req_data = 32'h44332211;
  logic [AS:0]     rd_g = '0;
  logic [NR-1:0]   gnt;
  logic            wr_en;
  logic [AS-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic [AS:0]     wr_ptr_gray;
  logic            full;
`ifdef FIFO_ARB_ALMOST_FULL_EN
  logic            almost_full;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  fifo_wr_arbiter #(.addr_size(AS), .data_width(DW), .NUM_REQ(NR), .AF_MARGIN(AFM)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .req              (req),
    .req_data         (req_data),
    .rd_ptr_gray_sync (rd_g),
    .gnt              (gnt),
    .wr_en            (wr_en),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .wr_ptr_gray      (wr_ptr_gray),
`ifdef FIFO_ARB_ALMOST_FULL_EN
    .almost_full      (almost_full),
`endif
    .full             (full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AS:0] to_gray(input int b);
    logic [AS:0] v;
    v = (AS+1)'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic do_reset();
    req = '0;
    rd_g = '0;
    @(negedge clk);
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  typedef struct {
    bit         rst;
    logic [3:0] req;
    int         rd;
    logic [3:0] gnt;
    logic       en;
    logic [1:0] addr;
    logic [7:0] data;
    logic       full;
  } vec_t;

  vec_t tbl[$];

  // Reference model state: pointers as plain write/read counts modulo 2*DEPTH.
  int m_wr, m_rd, m_last;
  bit m_full, m_af;
  logic [3:0] e_gnt;
  logic       e_en;
  logic [1:0] e_addr;
  logic [7:0] e_data;

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_last = NR - 1;
    m_full = 0; m_af = 0;
    e_gnt = '0; e_en = 0; e_addr = '0; e_data = '0;
  endtask

  task automatic model_step();
    int w, occ;
    bit found;
    found = 0;
    w = 0;
    if (req != 0 && !m_full) begin
      for (int k = 1; k <= NR; k++) begin
        if (!found && req[(m_last + k) % NR]) begin
          found = 1;
          w = (m_last + k) % NR;
        end
      end
    end
    if (found) begin
      e_gnt  = 4'(1 << w);
      e_en   = 1;
      e_addr = 2'(m_wr % DEPTH);
      e_data = req_data[w*DW +: DW];
      m_wr   = (m_wr + 1) % (2*DEPTH);
      m_last = w;
    end else begin
      e_gnt = '0;
      e_en  = 0;
    end
    occ    = (m_wr - m_rd + 2*DEPTH) % (2*DEPTH);
    m_full = (occ == DEPTH);
    m_af   = (occ >= DEPTH - AFM);
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".gnt"},   32'(gnt),         32'(e_gnt));
    chk({tag, ".wr_en"}, 32'(wr_en),       32'(e_en));
    chk({tag, ".addr"},  32'(wr_addr),     32'(e_addr));
    chk({tag, ".data"},  32'(wr_data),     32'(e_data));
    chk({tag, ".gray"},  32'(wr_ptr_gray), 32'(to_gray(m_wr)));
    chk({tag, ".full"},  32'(full),        32'(m_full));
`ifdef FIFO_ARB_ALMOST_FULL_EN
    chk({tag, ".af"},    32'(almost_full), 32'(m_af));
`endif
  endtask

  initial begin
    // fill to full on req0, read-advance release, round robin over all, then req0/req2 alternation
    tbl.push_back('{1, 4'h1, 0, 4'h1, 1, 2'd0, 8'h11, 0});
    tbl.push_back('{0, 4'h1, 0, 4'h1, 1, 2'd1, 8'h11, 0});
    tbl.push_back('{0, 4'h1, 0, 4'h1, 1, 2'd2, 8'h11, 0});
    tbl.push_back('{0, 4'h1, 0, 4'h1, 1, 2'd3, 8'h11, 1});
    tbl.push_back('{0, 4'h1, 0, 4'h0, 0, 2'd3, 8'h11, 1});
    tbl.push_back('{0, 4'h1, 1, 4'h0, 0, 2'd3, 8'h11, 0});
    tbl.push_back('{0, 4'h1, 1, 4'h1, 1, 2'd0, 8'h11, 1});
    tbl.push_back('{0, 4'h1, 1, 4'h0, 0, 2'd0, 8'h11, 1});
    tbl.push_back('{1, 4'hF, 0, 4'h1, 1, 2'd0, 8'h11, 0});
    tbl.push_back('{0, 4'hF, 1, 4'h2, 1, 2'd1, 8'h22, 0});
    tbl.push_back('{0, 4'hF, 2, 4'h4, 1, 2'd2, 8'h33, 0});
    tbl.push_back('{0, 4'hF, 3, 4'h8, 1, 2'd3, 8'h44, 0});
    tbl.push_back('{0, 4'hF, 4, 4'h1, 1, 2'd0, 8'h11, 0});
    tbl.push_back('{0, 4'h5, 5, 4'h4, 1, 2'd1, 8'h33, 0});
    tbl.push_back('{0, 4'h5, 6, 4'h1, 1, 2'd2, 8'h11, 0});
    tbl.push_back('{0, 4'h5, 7, 4'h4, 1, 2'd3, 8'h33, 0});
    tbl.push_back('{0, 4'h5, 0, 4'h1, 1, 2'd0, 8'h11, 0});

    #12;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst.gnt",  32'(gnt),         0);
    chk("rst.en",   32'(wr_en),       0);
    chk("rst.gray", 32'(wr_ptr_gray), 0);
    chk("rst.full", 32'(full),        0);

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      req  = tbl[i].req;
      rd_g = to_gray(tbl[i].rd);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.gnt", i),  32'(gnt),     32'(tbl[i].gnt));
      chk($sformatf("vec%0d.en", i),   32'(wr_en),   32'(tbl[i].en));
      chk($sformatf("vec%0d.addr", i), 32'(wr_addr), 32'(tbl[i].addr));
      chk($sformatf("vec%0d.data", i), 32'(wr_data), 32'(tbl[i].data));
      chk($sformatf("vec%0d.full", i), 32'(full),    32'(tbl[i].full));
      @(negedge clk);
    end

    // Async reset mid-burst clears outputs without a clock edge, then req0 wins first.
    do_reset();
    model_reset();
    req = 4'hE;
    for (int c = 0; c < 3; c++) begin
      model_step();
      @(posedge clk);
      #1;
      check_model("burst");
      @(negedge clk);
    end
    #2;
    reset_n = 1'b0;
    #1;
    chk("amid.gnt",  32'(gnt),         0);
    chk("amid.en",   32'(wr_en),       0);
    chk("amid.addr", 32'(wr_addr),     0);
    chk("amid.data", 32'(wr_data),     0);
    chk("amid.gray", 32'(wr_ptr_gray), 0);
    chk("amid.full", 32'(full),        0);
`ifdef FIFO_ARB_ALMOST_FULL_EN
    chk("amid.af",   32'(almost_full), 0);
`endif
    reset_n = 1'b1;
    model_reset();
    req = 4'hF;
    rd_g = '0;
    model_step();
    @(posedge clk);
    #1;
    check_model("post_rst");
    @(negedge clk);

    // Randomized traffic with phases of slow and fast draining.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      int occ;
      int pct;
      pct = ((c / 250) % 2 == 0) ? 30 : 90;
      req = 4'($urandom_range(0, 15));
      req_data = $urandom;
      occ = (m_wr - m_rd + 2*DEPTH) % (2*DEPTH);
      if (occ > 0 && $urandom_range(0, 99) < pct) m_rd = (m_rd + 1) % (2*DEPTH);
      rd_g = to_gray(m_rd);
      model_step();
      @(posedge clk);
      #1;
      check_model("rand");
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
